// File: rtl/phoenix_packet_buffer.sv
// phoenix_packet_buffer: per-port circular flit FIFO with credit return and packet-framing FSM.
// Optional occupancy port enabled by defining PHOENIX_BUF_OCC_EN.
module phoenix_packet_buffer #(
    parameter int TAM_FLIT = 16,
    parameter int DEPTH    = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                rx,
    input  logic [TAM_FLIT-1:0] data_in,
    output logic                credit_o,
    output logic                h,
    input  logic                ack_h,
    output logic                data_av,
    input  logic                data_ack,
    output logic                sender,
    output logic [TAM_FLIT-1:0] data
`ifdef PHOENIX_BUF_OCC_EN
    ,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    typedef enum logic [2:0] {IDLE, ROUTE, HDR, SIZE, PAYLOAD} state_t;
    state_t              state;
    logic [TAM_FLIT-1:0] mem [DEPTH];
    logic [AW-1:0]       rd_ptr, wr_ptr;
    logic [CW-1:0]       count;
    logic [TAM_FLIT-1:0] flits;
    logic                push, pop, empty;
    always_comb begin
        empty    = count == '0;
        credit_o = count != CW'(DEPTH);
        data_av  = sender && !empty;
        push     = rx && credit_o;
        pop      = data_av && data_ack;
        data     = mem[rd_ptr];
    end
`ifdef PHOENIX_BUF_OCC_EN
    assign occupancy = count;
`endif
    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= data_in;
    // Pointers wrap for free because DEPTH is a power of two.
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    always_ff @(posedge clock or posedge reset)
        if (reset) begin
            state  <= IDLE;
            h      <= 1'b0;
            sender <= 1'b0;
            flits  <= '0;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    state <= ROUTE;
                    h     <= 1'b1;
                end
                ROUTE: if (ack_h) begin
                    state  <= HDR;
                    h      <= 1'b0;
                    sender <= 1'b1;
                end
                HDR: if (pop) state <= SIZE;
                SIZE: if (pop) begin
                    flits <= data;
                    if (data == '0) begin
                        state  <= IDLE;
                        sender <= 1'b0;
                    end else state <= PAYLOAD;
                end
                PAYLOAD: if (pop) begin
                    flits <= flits - 1'b1;
                    if (flits == TAM_FLIT'(1)) begin
                        state  <= IDLE;
                        sender <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    h      <= 1'b0;
                    sender <= 1'b0;
                end
            endcase
        end
endmodule

// File: tb/tb_phoenix_packet_buffer.sv
// tb_phoenix_packet_buffer: directed scenario tests for phoenix_packet_buffer at DEPTH=4.
module tb_phoenix_packet_buffer;
    logic        clock = 1'b0;
    logic        reset, rx, ack_h, data_ack;
    logic [15:0] data_in;
    logic        credit_o, h, data_av, sender;
    logic [15:0] data;
`ifdef PHOENIX_BUF_OCC_EN
    logic [2:0]  occupancy;
`endif
    int tests = 0;
    int fails = 0;

    phoenix_packet_buffer #(.TAM_FLIT(16), .DEPTH(4)) dut (
        .clock(clock), .reset(reset), .rx(rx), .data_in(data_in),
        .credit_o(credit_o), .h(h), .ack_h(ack_h), .data_av(data_av),
        .data_ack(data_ack), .sender(sender), .data(data)
`ifdef PHOENIX_BUF_OCC_EN
        , .occupancy(occupancy)
`endif
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic test_reset();
        reset = 1'b1; rx = 1'b0; ack_h = 1'b0; data_ack = 1'b0; data_in = '0;
        tick(); tick();
        reset = 1'b0;
        tick();
        tests++;
        if ({credit_o, h, sender, data_av} !== 4'b1000) begin
            fails++; $display("FAIL reset_outputs got %b want 1000", {credit_o, h, sender, data_av});
        end
`ifdef PHOENIX_BUF_OCC_EN
        tests++;
        if (occupancy !== 3'd0) begin fails++; $display("FAIL reset_occ got %0d want 0", occupancy); end
`endif
        tick(); tick(); tick();
        tests++;
        if ({h, sender, data_av} !== 3'b000) begin
            fails++; $display("FAIL idle_stays got %b want 000", {h, sender, data_av});
        end
    endtask

    task automatic test_packet();
        logic [15:0] f [4];
        f[0] = 16'h0011; f[1] = 16'h0002; f[2] = 16'hAAAA; f[3] = 16'hBBBB;
        data_ack = 1'b1;
        rx = 1'b1; data_in = f[0]; tick();
        tests++;
        if (h !== 1'b0) begin fails++; $display("FAIL h_early got %b want 0", h); end
        data_in = f[1]; tick();
        tests++;
        if (h !== 1'b1) begin fails++; $display("FAIL h_rise got %b want 1", h); end
        data_in = f[2]; tick();
        data_in = f[3]; ack_h = 1'b1; tick();
        rx = 1'b0; ack_h = 1'b0;
        tests++;
        if ({h, sender, data_av, credit_o} !== 4'b0110) begin
            fails++; $display("FAIL grant got %b want 0110", {h, sender, data_av, credit_o});
        end
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (data !== f[i] || sender !== 1'b1) begin
                fails++; $display("FAIL pkt_flit%0d got %h/%b want %h/1", i, data, sender, f[i]);
            end
            tick();
        end
        tests++;
        if ({sender, data_av, credit_o, h} !== 4'b0010) begin
            fails++; $display("FAIL pkt_end got %b want 0010", {sender, data_av, credit_o, h});
        end
        data_ack = 1'b0;
    endtask

    task automatic test_full();
        for (int i = 0; i < 6; i++) begin
            rx = 1'b1; data_in = 16'h0100 + 16'(i); tick();
            if (i == 2) begin
                tests++;
                if (credit_o !== 1'b1) begin fails++; $display("FAIL credit_3 got %b want 1", credit_o); end
            end
            if (i == 3) begin
                tests++;
                if (credit_o !== 1'b0) begin fails++; $display("FAIL credit_4 got %b want 0", credit_o); end
            end
        end
        rx = 1'b0;
        tests++;
        if ({credit_o, h, data_av} !== 3'b010) begin
            fails++; $display("FAIL full_hold got %b want 010", {credit_o, h, data_av});
        end
`ifdef PHOENIX_BUF_OCC_EN
        tests++;
        if (occupancy !== 3'd4) begin fails++; $display("FAIL occ_full got %0d want 4", occupancy); end
`endif
        ack_h = 1'b1; tick(); ack_h = 1'b0;
        tests++;
        if (data_av !== 1'b1 || data !== 16'h0100) begin
            fails++; $display("FAIL full_head got %b/%h want 1/0100", data_av, data);
        end
        rx = 1'b1; data_in = 16'hDEAD; data_ack = 1'b1; tick(); rx = 1'b0;
        tests++;
        if (credit_o !== 1'b1 || data !== 16'h0101) begin
            fails++; $display("FAIL full_pop got %b/%h want 1/0101", credit_o, data);
        end
`ifdef PHOENIX_BUF_OCC_EN
        tests++;
        if (occupancy !== 3'd3) begin fails++; $display("FAIL occ_pop got %0d want 3", occupancy); end
`endif
        tick();
        tests++;
        if (data !== 16'h0102) begin fails++; $display("FAIL drain1 got %h want 0102", data); end
        tick();
        tests++;
        if (data !== 16'h0103) begin fails++; $display("FAIL drain2 got %h want 0103", data); end
        tick();
        tests++;
        if ({data_av, sender} !== 2'b01) begin
            fails++; $display("FAIL drain_empty got %b want 01", {data_av, sender});
        end
        data_ack = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 3; i++) begin
            rx = 1'b1; data_in = 16'h0200 + 16'(i); tick();
        end
        rx = 1'b0;
        tests++;
        if ({data_av, sender} !== 2'b11) begin
            fails++; $display("FAIL pre_reset got %b want 11", {data_av, sender});
        end
        reset = 1'b1;
        #1;
        tests++;
        if ({credit_o, h, sender, data_av} !== 4'b1000) begin
            fails++; $display("FAIL async_reset got %b want 1000", {credit_o, h, sender, data_av});
        end
`ifdef PHOENIX_BUF_OCC_EN
        tests++;
        if (occupancy !== 3'd0) begin fails++; $display("FAIL occ_reset got %0d want 0", occupancy); end
`endif
        tick(); reset = 1'b0; tick();
        tests++;
        if ({h, sender} !== 2'b00) begin fails++; $display("FAIL after_reset got %b want 00", {h, sender}); end
    endtask

    task automatic test_back_to_back();
        rx = 1'b1; data_in = 16'h0A01; tick();
        data_in = 16'h0000; tick();
        data_in = 16'h0B02; ack_h = 1'b1; data_ack = 1'b1; tick();
        data_in = 16'h0000; ack_h = 1'b0;
        tests++;
        if ({h, sender} !== 2'b01 || data !== 16'h0A01) begin
            fails++; $display("FAIL b2b_hdr got %b/%h want 01/0a01", {h, sender}, data);
        end
        tick(); rx = 1'b0;
        tests++;
        if (data !== 16'h0000 || sender !== 1'b1) begin
            fails++; $display("FAIL b2b_size got %h/%b want 0000/1", data, sender);
        end
        tick();
        tests++;
        if ({sender, h, data_av} !== 3'b000 || data !== 16'h0B02) begin
            fails++; $display("FAIL b2b_idle got %b/%h want 000/0b02", {sender, h, data_av}, data);
        end
        tick();
        tests++;
        if (h !== 1'b1) begin fails++; $display("FAIL b2b_h2 got %b want 1", h); end
        ack_h = 1'b1; tick(); ack_h = 1'b0;
        tests++;
        if (data !== 16'h0B02 || sender !== 1'b1) begin
            fails++; $display("FAIL b2b_hdr2 got %h/%b want 0b02/1", data, sender);
        end
        tick(); tick();
        tests++;
        if ({sender, data_av, credit_o} !== 3'b001) begin
            fails++; $display("FAIL b2b_end got %b want 001", {sender, data_av, credit_o});
        end
        data_ack = 1'b0;
    endtask

    task automatic test_wrap();
        logic [15:0] exp_q [30];
        int ri = 0;
        int wi = 0;
        for (int i = 0; i < 10; i++) begin
            exp_q[3*i]   = 16'h0100 + 16'(i);
            exp_q[3*i+1] = 16'h0001;
            exp_q[3*i+2] = 16'h5000 + 16'(i);
        end
        ack_h = 1'b1; data_ack = 1'b1;
        for (int c = 0; c < 400 && ri < 30; c++) begin
            if (data_av) begin
                tests++;
                if (data !== exp_q[ri]) begin
                    fails++; $display("FAIL wrap_flit%0d got %h want %h", ri, data, exp_q[ri]);
                end
                ri++;
            end
            if (wi < 30 && credit_o) begin
                rx = 1'b1; data_in = exp_q[wi]; wi++;
            end else rx = 1'b0;
            tick();
        end
        rx = 1'b0;
        tests++;
        if (ri != 30) begin fails++; $display("FAIL wrap_timeout got %0d flits want 30", ri); end
        tests++;
        if ({sender, data_av, credit_o} !== 3'b001) begin
            fails++; $display("FAIL wrap_end got %b want 001", {sender, data_av, credit_o});
        end
        ack_h = 1'b0; data_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_packet();
        test_full();
        test_async_reset();
        test_back_to_back();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
